// File: rtl/timer_irq_master_pkg.sv
// Shared definitions for the interval-timer Avalon-MM initiator: register map,
// control bit positions and FSM encoding.
package timer_irq_master_pkg;

    localparam logic [2:0] REG_STATUS   = 3'd0;
    localparam logic [2:0] REG_CONTROL  = 3'd1;
    localparam logic [2:0] REG_PERIOD_L = 3'd2;
    localparam logic [2:0] REG_PERIOD_H = 3'd3;
    localparam logic [2:0] REG_SNAP_L   = 3'd4;
    localparam logic [2:0] REG_SNAP_H   = 3'd5;

    localparam int CTL_ITO   = 0;
    localparam int CTL_CONT  = 1;
    localparam int CTL_START = 2;
    localparam int CTL_STOP  = 3;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CFG_PL,
        ST_CFG_PH,
        ST_CFG_CTL,
        ST_RUN,
        ST_ACK,
        ST_ACK_GUARD,
        ST_SNAP_WR,
        ST_SNAP_RL,
        ST_SNAP_WL,
        ST_SNAP_RH,
        ST_SNAP_WH,
        ST_STOP_WR
    } state_t;

    function automatic logic [15:0] start_word(input logic cont);
        logic [15:0] w;
        w            = '0;
        w[CTL_ITO]   = 1'b1;
        w[CTL_CONT]  = cont;
        w[CTL_START] = 1'b1;
        return w;
    endfunction

    function automatic logic [15:0] stop_word();
        logic [15:0] w;
        w           = '0;
        w[CTL_STOP] = 1'b1;
        return w;
    endfunction

endpackage

// File: rtl/timer_irq_master.sv
// Avalon-MM initiator that programs a 16-bit interval timer, services its
// timeout irq as a tick source and takes on-demand counter snapshots.
module timer_irq_master
    import timer_irq_master_pkg::*;
#(
    parameter int TICK_W     = 32,
    parameter bit CONTINUOUS = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              stop,
    input  logic [31:0]       cfg_period,
    input  logic              snap_req,
    output logic [2:0]        avm_address,
    output logic              avm_chipselect,
    output logic              avm_write_n,
    output logic [15:0]       avm_writedata,
    input  logic [15:0]       avm_readdata,
    input  logic              timer_irq,
    output logic              busy,
    output logic              running,
    output logic              tick_pulse,
    output logic [TICK_W-1:0] tick_count,
    output logic [31:0]       snap_value,
    output logic              snap_valid,
    output logic [3:0]        fsm_state
);

    // Bus handshake: no waitrequest, so an access completes in its strobe
    // cycle; read data is valid in the cycle after the strobe (the WAIT state).
    state_t      state;
    logic [15:0] period_hi;
    logic        stop_pend;
    logic        snap_pend;

    assign busy      = (state != ST_IDLE) && (state != ST_RUN);
    assign fsm_state = state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_IDLE;
            period_hi      <= '0;
            stop_pend      <= 1'b0;
            snap_pend      <= 1'b0;
            avm_address    <= '0;
            avm_chipselect <= 1'b0;
            avm_write_n    <= 1'b1;
            avm_writedata  <= '0;
            running        <= 1'b0;
            tick_pulse     <= 1'b0;
            tick_count     <= '0;
            snap_value     <= '0;
            snap_valid     <= 1'b0;
        end else begin
            avm_chipselect <= 1'b0;
            avm_write_n    <= 1'b1;
            tick_pulse     <= 1'b0;
            snap_valid     <= 1'b0;
            if (stop)     stop_pend <= 1'b1;
            if (snap_req) snap_pend <= 1'b1;

            case (state)
                ST_IDLE: begin
                    // A lone stop has nothing to stop; one paired with start is kept.
                    stop_pend <= start & stop;
                    if (start) begin
                        period_hi      <= cfg_period[31:16];
                        avm_address    <= REG_PERIOD_L;
                        avm_writedata  <= cfg_period[15:0];
                        avm_chipselect <= 1'b1;
                        avm_write_n    <= 1'b0;
                        state          <= ST_CFG_PL;
                    end else if (snap_pend || snap_req) begin
                        snap_pend      <= 1'b0;
                        avm_address    <= REG_SNAP_L;
                        avm_writedata  <= '0;
                        avm_chipselect <= 1'b1;
                        avm_write_n    <= 1'b0;
                        state          <= ST_SNAP_WR;
                    end
                end
                ST_CFG_PL: begin
                    avm_address    <= REG_PERIOD_H;
                    avm_writedata  <= period_hi;
                    avm_chipselect <= 1'b1;
                    avm_write_n    <= 1'b0;
                    state          <= ST_CFG_PH;
                end
                ST_CFG_PH: begin
                    avm_address    <= REG_CONTROL;
                    avm_writedata  <= start_word(CONTINUOUS);
                    avm_chipselect <= 1'b1;
                    avm_write_n    <= 1'b0;
                    state          <= ST_CFG_CTL;
                end
                ST_CFG_CTL: begin
                    running <= 1'b1;
                    state   <= ST_RUN;
                end
                ST_RUN: begin
                    if (stop_pend || stop) begin
                        stop_pend      <= 1'b0;
                        avm_address    <= REG_CONTROL;
                        avm_writedata  <= stop_word();
                        avm_chipselect <= 1'b1;
                        avm_write_n    <= 1'b0;
                        state          <= ST_STOP_WR;
                    end else if (timer_irq) begin
                        avm_address    <= REG_STATUS;
                        avm_writedata  <= '0;
                        avm_chipselect <= 1'b1;
                        avm_write_n    <= 1'b0;
                        state          <= ST_ACK;
                    end else if (snap_pend || snap_req) begin
                        snap_pend      <= 1'b0;
                        avm_address    <= REG_SNAP_L;
                        avm_writedata  <= '0;
                        avm_chipselect <= 1'b1;
                        avm_write_n    <= 1'b0;
                        state          <= ST_SNAP_WR;
                    end
                end
                ST_ACK: begin
                    tick_pulse <= 1'b1;
                    tick_count <= tick_count + TICK_W'(1);
                    state      <= ST_ACK_GUARD;
                end
                // The slave's irq lags the status clear by a cycle; skip it.
                ST_ACK_GUARD: state <= ST_RUN;
                ST_SNAP_WR: begin
                    avm_address    <= REG_SNAP_L;
                    avm_chipselect <= 1'b1;
                    state          <= ST_SNAP_RL;
                end
                ST_SNAP_RL: state <= ST_SNAP_WL;
                ST_SNAP_WL: begin
                    snap_value[15:0] <= avm_readdata;
                    avm_address      <= REG_SNAP_H;
                    avm_chipselect   <= 1'b1;
                    state            <= ST_SNAP_RH;
                end
                ST_SNAP_RH: state <= ST_SNAP_WH;
                ST_SNAP_WH: begin
                    snap_value[31:16] <= avm_readdata;
                    snap_valid        <= 1'b1;
                    state             <= running ? ST_RUN : ST_IDLE;
                end
                ST_STOP_WR: begin
                    running <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_timer_irq_master.sv
// Bench for timer_irq_master: behavioural timer slave with registered readdata
// and a bus-access scoreboard fed by each scenario task.
module tb_timer_irq_master;

    localparam int TICK_W = 4;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              start, stop, snap_req, timer_irq;
    logic [31:0]       cfg_period;
    logic [2:0]        avm_address;
    logic              avm_chipselect, avm_write_n;
    logic [15:0]       avm_writedata, avm_readdata;
    logic              busy, running, tick_pulse, snap_valid;
    logic [TICK_W-1:0] tick_count;
    logic [31:0]       snap_value;
    logic [3:0]        fsm_state;

    logic [31:0] counter_val;
    logic [15:0] snap_l, snap_h;
    logic [19:0] exp_q[$];
    int checks = 0;
    int failures = 0;
    int pulse_cnt = 0;
    int snap_cnt = 0;
    int snap_at = 0;

    always #5 clk = ~clk;

    timer_irq_master #(.TICK_W(TICK_W), .CONTINUOUS(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .stop(stop),
        .cfg_period(cfg_period), .snap_req(snap_req),
        .avm_address(avm_address), .avm_chipselect(avm_chipselect),
        .avm_write_n(avm_write_n), .avm_writedata(avm_writedata),
        .avm_readdata(avm_readdata), .timer_irq(timer_irq),
        .busy(busy), .running(running), .tick_pulse(tick_pulse),
        .tick_count(tick_count), .snap_value(snap_value),
        .snap_valid(snap_valid), .fsm_state(fsm_state)
    );

    // Timer slave model: snapshot registers latch on a write to addr4,
    // readdata is registered and garbage outside a read.
    always @(posedge clk) begin
        if (avm_chipselect && !avm_write_n && avm_address == 3'd4) begin
            snap_l <= counter_val[15:0];
            snap_h <= counter_val[31:16];
        end
        if (avm_chipselect && avm_write_n)
            avm_readdata <= (avm_address == 3'd4) ? snap_l :
                            (avm_address == 3'd5) ? snap_h : 16'h0000;
        else
            avm_readdata <= 16'hDEAD;
    end

    function automatic logic [19:0] wr_exp(input logic [2:0] a, input logic [15:0] d);
        return {1'b0, a, d};
    endfunction

    function automatic logic [19:0] rd_exp(input logic [2:0] a);
        return {1'b1, a, 16'h0000};
    endfunction

    // One clock step; samples mid-cycle and scores any bus access seen.
    task automatic cycle();
        logic [19:0] obs, exp;
        @(negedge clk);
        pulse_cnt += int'(tick_pulse);
        snap_cnt  += int'(snap_valid);
        if (avm_chipselect) begin
            obs = {avm_write_n, avm_address, avm_write_n ? 16'h0000 : avm_writedata};
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL bus_unexpected got=%h required=none", obs);
            end else begin
                exp = exp_q.pop_front();
                if (obs !== exp) begin
                    failures++;
                    $display("FAIL bus_access got=%h required=%h", obs, exp);
                end
            end
        end
    endtask

    task automatic start_timer(input logic [31:0] p, input logic with_stop);
        exp_q.push_back(wr_exp(3'd2, p[15:0]));
        exp_q.push_back(wr_exp(3'd3, p[31:16]));
        exp_q.push_back(wr_exp(3'd1, 16'h0007));
        start = 1'b1; stop = with_stop; cfg_period = p;
        cycle();
        start = 1'b0; stop = 1'b0; cfg_period = $urandom;
        repeat (3) cycle();
    endtask

    task automatic stop_timer();
        exp_q.push_back(wr_exp(3'd1, 16'h0008));
        stop = 1'b1;
        cycle();
        stop = 1'b0;
        repeat (3) cycle();
    endtask

    // irq stays high one cycle past the clear, as the real slave's does.
    task automatic do_tick(output bit seen, output bit pulsed);
        int p0;
        p0 = pulse_cnt;
        seen = 1'b0;
        exp_q.push_back(wr_exp(3'd0, 16'h0000));
        timer_irq = 1'b1;
        for (int i = 0; i < 8 && !seen; i++) begin
            cycle();
            if (avm_chipselect && !avm_write_n && avm_address == 3'd0) seen = 1'b1;
        end
        cycle();
        pulsed = tick_pulse;
        cycle();
        timer_irq = 1'b0;
        repeat (2) cycle();
        pulsed = pulsed && (pulse_cnt == p0 + 1);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; stop = 1'b0; snap_req = 1'b0;
        timer_irq = 1'b0; cfg_period = '0; counter_val = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        cycle();
        checks++;
        if ({avm_chipselect, avm_write_n, avm_address, avm_writedata} !== {1'b0, 1'b1, 3'd0, 16'h0}) begin
            failures++;
            $display("FAIL reset_bus got=%b_%b_%h_%h required=0_1_0_0000",
                     avm_chipselect, avm_write_n, avm_address, avm_writedata);
        end
        checks++;
        if ({busy, running, tick_pulse, snap_valid} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_flags got=%b required=0000", {busy, running, tick_pulse, snap_valid});
        end
        checks++;
        if (tick_count !== '0 || snap_value !== 32'h0) begin
            failures++;
            $display("FAIL reset_values got=%h_%h required=0_0", tick_count, snap_value);
        end
    endtask

    task automatic test_program();
        exp_q.push_back(wr_exp(3'd2, 16'h0009));
        exp_q.push_back(wr_exp(3'd3, 16'h0000));
        exp_q.push_back(wr_exp(3'd1, 16'h0007));
        start = 1'b1; cfg_period = 32'h0000_0009;
        cycle();
        start = 1'b0; cfg_period = 32'hFFFF_FFFF;
        checks++;
        if (!(avm_chipselect && !avm_write_n && busy)) begin
            failures++;
            $display("FAIL program_latency got=cs%b wn%b busy%b required=cs1 wn0 busy1",
                     avm_chipselect, avm_write_n, busy);
        end
        repeat (3) cycle();
        checks++;
        if ({running, busy} !== 2'b10) begin
            failures++;
            $display("FAIL program_run got=%b required=10", {running, busy});
        end
    endtask

    task automatic test_ticks();
        bit seen, pulsed;
        int p0;
        p0 = pulse_cnt;
        for (int t = 0; t < 3; t++) begin
            do_tick(seen, pulsed);
            checks++;
            if (!seen || !pulsed) begin
                failures++;
                $display("FAIL tick_%0d got=ack%b pulse%b required=ack1 pulse1", t, seen, pulsed);
            end
        end
        repeat (3) cycle();
        checks++;
        if (tick_count !== 4'd3 || pulse_cnt - p0 != 3) begin
            failures++;
            $display("FAIL tick_total got=count%0d pulses%0d required=count3 pulses3",
                     tick_count, pulse_cnt - p0);
        end
    endtask

    task automatic test_snapshot();
        int s0;
        s0 = snap_cnt;
        snap_at = 0;
        counter_val = 32'h0001_0005;
        exp_q.push_back(wr_exp(3'd4, 16'h0000));
        exp_q.push_back(rd_exp(3'd4));
        exp_q.push_back(rd_exp(3'd5));
        snap_req = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            cycle();
            snap_req = 1'b0;
            if (snap_valid && snap_at == 0) snap_at = i;
        end
        checks++;
        if (snap_value !== 32'h0001_0005) begin
            failures++;
            $display("FAIL snap_value got=%h required=00010005", snap_value);
        end
        checks++;
        if (snap_cnt - s0 != 1 || snap_at != 6) begin
            failures++;
            $display("FAIL snap_valid got=pulses%0d at%0d required=pulses1 at6", snap_cnt - s0, snap_at);
        end
        checks++;
        if (running !== 1'b1) begin
            failures++;
            $display("FAIL snap_running got=%b required=1", running);
        end
    endtask

    task automatic test_stop_priority();
        counter_val = 32'hA5A5_1234;
        exp_q.push_back(wr_exp(3'd1, 16'h0008));
        exp_q.push_back(wr_exp(3'd4, 16'h0000));
        exp_q.push_back(rd_exp(3'd4));
        exp_q.push_back(rd_exp(3'd5));
        timer_irq = 1'b1; snap_req = 1'b1; stop = 1'b1;
        cycle();
        snap_req = 1'b0; stop = 1'b0;
        repeat (12) cycle();
        timer_irq = 1'b0;
        checks++;
        if ({running, busy} !== 2'b00) begin
            failures++;
            $display("FAIL stop_idle got=%b required=00", {running, busy});
        end
        checks++;
        if (snap_value !== 32'hA5A5_1234 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL stop_snap got=%h left%0d required=a5a51234 left0", snap_value, exp_q.size());
        end
    endtask

    task automatic test_reset_mid_cfg();
        exp_q.push_back(wr_exp(3'd2, 16'h1111));
        exp_q.push_back(wr_exp(3'd3, 16'h2222));
        start = 1'b1; cfg_period = 32'h2222_1111;
        cycle();
        start = 1'b0;
        cycle();
        reset_n = 1'b0;
        #1;
        checks++;
        if ({avm_chipselect, avm_write_n, busy, running} !== 4'b0100) begin
            failures++;
            $display("FAIL midreset_bus got=%b required=0100", {avm_chipselect, avm_write_n, busy, running});
        end
        checks++;
        if (tick_count !== '0 || snap_value !== 32'h0) begin
            failures++;
            $display("FAIL midreset_values got=%h_%h required=0_0", tick_count, snap_value);
        end
        exp_q.delete();
        cycle();
        reset_n = 1'b1;
        cycle();
        start_timer(32'(($urandom_range(1, 65535) << 16) | $urandom_range(0, 65535)), 1'b0);
        checks++;
        if (running !== 1'b1 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL midreset_reprogram got=run%b left%0d required=run1 left0", running, exp_q.size());
        end
    endtask

    task automatic test_wrap();
        bit seen, pulsed;
        for (int t = 0; t < 16; t++) begin
            do_tick(seen, pulsed);
            checks++;
            if (!seen || !pulsed) begin
                failures++;
                $display("FAIL wrap_tick_%0d got=ack%b pulse%b required=ack1 pulse1", t, seen, pulsed);
            end
            if (t >= 14) begin
                checks++;
                if (tick_count !== TICK_W'(t + 1)) begin
                    failures++;
                    $display("FAIL wrap_count_%0d got=%0d required=%0d", t, tick_count, TICK_W'(t + 1));
                end
            end
        end
    endtask

    task automatic test_start_stop();
        stop_timer();
        stop = 1'b1;
        cycle();
        stop = 1'b0;
        start_timer(32'($urandom_range(2, 1000)), 1'b0);
        repeat (6) cycle();
        checks++;
        if (running !== 1'b1) begin
            failures++;
            $display("FAIL idle_stop_dropped got=%b required=1", running);
        end
        stop_timer();
        start_timer(32'h0000_0040, 1'b1);
        exp_q.push_back(wr_exp(3'd1, 16'h0008));
        repeat (6) cycle();
        checks++;
        if (running !== 1'b0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL start_stop got=run%b left%0d required=run0 left0", running, exp_q.size());
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_program();
        test_ticks();
        test_snapshot();
        test_stop_priority();
        test_reset_mid_cfg();
        test_wrap();
        test_start_stop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
